// File: rtl/prog_intr_ctrl.sv
// Programmable interrupt controller: edge/level request latching, mask, fully nested
// in-service tracking, fixed or rotating priority and a single-cycle acknowledge handshake.
module prog_intr_ctrl #(
  parameter int N_IRQ = 8,
  parameter int VEC_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic             i_wr_en,
  input  logic             i_rd_en,
  input  logic [1:0]       i_addr,
  input  logic [N_IRQ-1:0] i_wdata,
  output logic [N_IRQ-1:0] o_rdata,
  output logic             o_int_out,
  input  logic             i_inta,
  output logic [VEC_W-1:0] o_vec_out,
  output logic             o_vec_valid
);
  localparam int ID_W = $clog2(N_IRQ);
  localparam logic [ID_W-1:0] LP_LAST = ID_W'(N_IRQ - 1);

  // IDLE: no request raised | REQ: int_out high, waiting for inta | ACK: vector presented
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_ACK = 2'd2} state_t;

  state_t           r_state, w_state_nxt;
  logic [N_IRQ-1:0] r_imr, r_irr, r_isr, r_irq_d, r_rdata;
  logic [2:0]       r_mode;
  logic [VEC_W-1:0] r_vbase, r_vec_out;
  logic [ID_W-1:0]  r_ptr, r_id;
  logic             r_aeoi_pend, r_int_out, r_vec_valid;

  logic [ID_W-1:0]  w_ptr, w_cand_id, w_isr_id, w_sel, w_eoi_id, w_ptr_val;
  logic [N_IRQ-1:0] w_req, w_set_mask, w_clr_mask, w_isr_nxt, w_irr_nxt;
  logic             w_cand_vld, w_isr_found, w_int_nxt, w_ack_go, w_grant;
  logic             w_eoi_wr, w_ptr_upd;
  int               w_idx;

  // Fixed priority is rotating priority with the pointer parked on the last index.
  assign w_ptr    = r_mode[1] ? r_ptr : LP_LAST;
  assign w_req    = r_irr & ~r_imr;
  assign w_eoi_wr = i_wr_en && (i_addr == 2'd3);
  assign w_eoi_id = i_wdata[ID_W-1:0];
  assign w_grant  = w_ack_go & w_cand_vld;

  always_comb begin
    w_cand_vld  = 1'b0;
    w_cand_id   = '0;
    w_isr_found = 1'b0;
    w_isr_id    = '0;
    w_idx       = 0;
    w_sel       = '0;
    for (int k = 0; k < N_IRQ; k++) begin
      w_idx = int'(w_ptr) + 1 + k;
      if (w_idx >= N_IRQ) w_idx = w_idx - N_IRQ;
      w_sel = ID_W'(w_idx);
      if (r_isr[w_sel] && !w_isr_found) begin
        w_isr_found = 1'b1;
        w_isr_id    = w_sel;
      end
      if (w_req[w_sel] && !w_cand_vld && !w_isr_found) begin
        w_cand_vld = 1'b1;
        w_cand_id  = w_sel;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_int_nxt   = r_int_out;
    w_ack_go    = 1'b0;
    case (r_state)
      S_IDLE: if (w_cand_vld) begin
        w_state_nxt = S_REQ;
        w_int_nxt   = 1'b1;
      end
      S_REQ: if (i_inta) begin
        w_state_nxt = S_ACK;
        w_int_nxt   = 1'b0;
        w_ack_go    = 1'b1;
      end
      S_ACK: begin
        w_state_nxt = w_cand_vld ? S_REQ : S_IDLE;
        w_int_nxt   = w_cand_vld;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_int_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_int_out <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_int_out <= w_int_nxt;
    end
  end

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    w_ptr_upd  = 1'b0;
    w_ptr_val  = r_ptr;
    if (w_grant) w_set_mask[w_cand_id] = 1'b1;
    if (r_state == S_ACK && r_aeoi_pend) begin
      w_clr_mask[r_id] = 1'b1;
      w_ptr_upd        = 1'b1;
      w_ptr_val        = r_id;
    end
    if (w_eoi_wr) begin
      if (i_wdata[7]) begin
        if (int'(w_eoi_id) < N_IRQ && r_isr[w_eoi_id]) begin
          w_clr_mask[w_eoi_id] = 1'b1;
          w_ptr_upd            = 1'b1;
          w_ptr_val            = w_eoi_id;
        end
      end else if (w_isr_found) begin
        w_clr_mask[w_isr_id] = 1'b1;
        w_ptr_upd            = 1'b1;
        w_ptr_val            = w_isr_id;
      end
    end
    if (!r_mode[1]) w_ptr_upd = 1'b0;
    w_isr_nxt = (r_isr & ~w_clr_mask) | w_set_mask;
    // A fresh edge on the bit being acknowledged re-arms it.
    w_irr_nxt = r_mode[0] ? i_irq : ((r_irr & ~w_set_mask) | (i_irq & ~r_irq_d));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_imr       <= '1;
      r_mode      <= '0;
      r_vbase     <= '0;
      r_irr       <= '0;
      r_isr       <= '0;
      r_irq_d     <= '0;
      r_ptr       <= LP_LAST;
      r_id        <= '0;
      r_aeoi_pend <= 1'b0;
      r_vec_valid <= 1'b0;
      r_vec_out   <= '0;
      r_rdata     <= '0;
    end else begin
      r_irq_d     <= i_irq;
      r_irr       <= w_irr_nxt;
      r_isr       <= w_isr_nxt;
      r_vec_valid <= w_ack_go;
      r_aeoi_pend <= w_grant & r_mode[2];
      if (w_ptr_upd) r_ptr <= w_ptr_val;
      if (w_ack_go) begin
        r_id      <= w_cand_id;
        r_vec_out <= w_grant ? (r_vbase + VEC_W'(w_cand_id)) : (r_vbase + VEC_W'(N_IRQ - 1));
      end
      if (i_wr_en) begin
        case (i_addr)
          2'd0:    r_imr   <= i_wdata;
          2'd1:    r_mode  <= i_wdata[2:0];
          2'd2:    r_vbase <= VEC_W'(i_wdata);
          default: ;
        endcase
      end
      if (i_rd_en) begin
        case (i_addr)
          2'd0:    r_rdata <= r_imr;
          2'd1:    r_rdata <= r_irr;
          2'd2:    r_rdata <= r_isr;
          default: r_rdata <= N_IRQ'(r_mode);
        endcase
      end
    end
  end

  assign o_rdata     = r_rdata;
  assign o_int_out   = r_int_out;
  assign o_vec_out   = r_vec_out;
  assign o_vec_valid = r_vec_valid;
endmodule

// File: tb/tb_prog_intr_ctrl.sv
// Bench for prog_intr_ctrl: reset checks, directed handshake sequences, a priority
// vector table and randomized traffic compared against a transaction-level model.
module tb_prog_intr_ctrl;
  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en, inta;
  logic [7:0] irq, wdata, rdata, vec_out;
  logic [1:0] addr;
  logic       int_out, vec_valid;

  always #5 clk = ~clk;

  prog_intr_ctrl #(.N_IRQ(8), .VEC_W(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_irq(irq), .i_wr_en(wr_en), .i_rd_en(rd_en),
    .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata), .o_int_out(int_out),
    .i_inta(inta), .o_vec_out(vec_out), .o_vec_valid(vec_valid)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; irq = '0; wr_en = 1'b0; rd_en = 1'b0; inta = 1'b0; addr = '0; wdata = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    rd_en = 1'b1; addr = a;
    tick();
    rd_en = 1'b0;
    d = rdata;
  endtask

  task automatic pulse(input logic [7:0] p);
    irq = p;
    tick();
    irq = '0;
  endtask

  task automatic do_inta();
    inta = 1'b1;
    tick();
    inta = 1'b0;
  endtask

  // Transaction-level reference model
  logic [7:0] m_irr, m_isr, m_imr, m_vbase;
  logic       m_rot, m_aeoi, m_int;
  int         m_ptr;

  function automatic int rank(input int i);
    int p;
    p = m_rot ? m_ptr : 7;
    return (i - p - 1 + 16) % 8;
  endfunction

  function automatic int m_best(input logic [7:0] b);
    int best;
    best = -1;
    for (int i = 0; i < 8; i++)
      if (b[i] && (best < 0 || rank(i) < rank(best))) best = i;
    return best;
  endfunction

  function automatic int m_cand();
    int r, s;
    r = m_best(m_irr & ~m_imr);
    s = m_best(m_isr);
    if (r >= 0 && (s < 0 || rank(r) < rank(s))) return r;
    return -1;
  endfunction

  typedef struct {
    logic [7:0] imr;
    logic [7:0] irq;
    logic [7:0] vbase;
    logic       exp_int;
    logic [7:0] exp_vec;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0] d, ex, p, exp_v;
    int         c, op, id;

    tbl[0] = '{8'h00, 8'h08, 8'h00, 1'b1, 8'h03};
    tbl[1] = '{8'h00, 8'h24, 8'h40, 1'b1, 8'h42};
    tbl[2] = '{8'h04, 8'h24, 8'h40, 1'b1, 8'h45};
    tbl[3] = '{8'hFF, 8'h81, 8'h10, 1'b0, 8'h00};
    tbl[4] = '{8'h00, 8'h80, 8'h20, 1'b1, 8'h27};
    tbl[5] = '{8'hF0, 8'hF1, 8'h08, 1'b1, 8'h08};
    tbl[6] = '{8'h0F, 8'hF1, 8'h08, 1'b1, 8'h0C};
    tbl[7] = '{8'h00, 8'h01, 8'hF0, 1'b1, 8'hF0};

    // reset state
    do_reset();
    chk("rst_int_out", 32'(int_out), 32'h0);
    chk("rst_vec_valid", 32'(vec_valid), 32'h0);
    chk("rst_vec_out", 32'(vec_out), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    rd(2'd0, d); chk("rst_imr", 32'(d), 32'hFF);
    rd(2'd1, d); chk("rst_irr", 32'(d), 32'h00);
    rd(2'd2, d); chk("rst_isr", 32'(d), 32'h00);
    rd(2'd3, d); chk("rst_mode", 32'(d), 32'h00);
    do_inta();
    chk("idle_inta_ignored", 32'(vec_valid), 32'h0);
    wr(2'd3, 8'h00);
    rd(2'd2, d); chk("eoi_empty_isr", 32'(d), 32'h00);

    // basic edge request, latency and vector
    wr(2'd0, 8'h00);
    pulse(8'h08);
    chk("t1_int_early", 32'(int_out), 32'h0);
    tick();
    chk("t1_int", 32'(int_out), 32'h1);
    do_inta();
    chk("t1_vvalid", 32'(vec_valid), 32'h1);
    chk("t1_vec", 32'(vec_out), 32'h03);
    chk("t1_int_drop", 32'(int_out), 32'h0);
    tick();
    chk("t1_vvalid_pulse", 32'(vec_valid), 32'h0);
    rd(2'd2, d); chk("t1_isr", 32'(d), 32'h08);
    rd(2'd1, d); chk("t1_irr", 32'(d), 32'h00);

    // nesting: lower priority held off until EOI
    do_reset();
    wr(2'd0, 8'h00); wr(2'd2, 8'h40);
    pulse(8'h24); tick(); tick();
    chk("t2_int", 32'(int_out), 32'h1);
    do_inta();
    chk("t2_vec1", 32'(vec_out), 32'h42);
    repeat (4) tick();
    chk("t2_held_off", 32'(int_out), 32'h0);
    rd(2'd1, d); chk("t2_irr", 32'(d), 32'h20);
    wr(2'd3, 8'h00);
    chk("t2_int_eoi_edge", 32'(int_out), 32'h0);
    tick();
    chk("t2_int_reassert", 32'(int_out), 32'h1);
    do_inta();
    chk("t2_vec2", 32'(vec_out), 32'h45);

    // rotating priority
    do_reset();
    wr(2'd0, 8'h00); wr(2'd1, 8'h02);
    pulse(8'h01); tick(); tick();
    do_inta();
    chk("t3_vec0", 32'(vec_out), 32'h00);
    wr(2'd3, 8'h00); tick();
    pulse(8'h81); tick(); tick();
    chk("t3_int", 32'(int_out), 32'h1);
    do_inta();
    chk("t3_vec7", 32'(vec_out), 32'h07);
    tick();
    rd(2'd2, d); chk("t3_isr", 32'(d), 32'h80);
    wr(2'd3, 8'h00); tick(); tick();
    do_inta();
    chk("t3_vec0_again", 32'(vec_out), 32'h00);

    // level mode, request drops before inta -> spurious
    do_reset();
    wr(2'd0, 8'h00); wr(2'd2, 8'h10); wr(2'd1, 8'h01);
    irq = 8'h10; tick(); tick(); tick();
    chk("t4_int", 32'(int_out), 32'h1);
    irq = 8'h00; repeat (3) tick();
    chk("t4_int_stays", 32'(int_out), 32'h1);
    do_inta();
    chk("t4_vvalid", 32'(vec_valid), 32'h1);
    chk("t4_spurious_vec", 32'(vec_out), 32'h17);
    tick();
    rd(2'd2, d); chk("t4_isr", 32'(d), 32'h00);
    irq = 8'h10; tick(); tick(); tick();
    chk("t4b_int", 32'(int_out), 32'h1);
    irq = 8'h00; rst = 1'b1; tick(); rst = 1'b0;
    chk("t4b_rst_int", 32'(int_out), 32'h0);
    do_inta();
    chk("t4b_rst_vvalid", 32'(vec_valid), 32'h0);

    // auto-EOI with mask
    do_reset();
    wr(2'd1, 8'h04); wr(2'd0, 8'hFE);
    pulse(8'h03); tick(); tick();
    chk("t5_int", 32'(int_out), 32'h1);
    do_inta();
    chk("t5_vec", 32'(vec_out), 32'h00);
    tick(); tick();
    rd(2'd2, d); chk("t5_isr", 32'(d), 32'h00);
    rd(2'd1, d); chk("t5_irr", 32'(d), 32'h02);
    chk("t5_int_idle", 32'(int_out), 32'h0);

    // specific EOI coincident with a new edge on the same bit
    do_reset();
    wr(2'd0, 8'h00); wr(2'd2, 8'h20);
    pulse(8'h40); tick(); tick();
    do_inta();
    chk("t6_vec1", 32'(vec_out), 32'h26);
    tick();
    rd(2'd2, d); chk("t6_isr_set", 32'(d), 32'h40);
    irq = 8'h40; wr_en = 1'b1; addr = 2'd3; wdata = 8'h86;
    tick();
    irq = 8'h00; wr_en = 1'b0;
    rd(2'd2, d); chk("t6_isr_clr", 32'(d), 32'h00);
    rd(2'd1, d); chk("t6_irr_set", 32'(d), 32'h40);
    tick();
    chk("t6_int", 32'(int_out), 32'h1);
    do_inta();
    chk("t6_vec2", 32'(vec_out), 32'h26);

    // table-driven priority vectors
    for (int i = 0; i < 8; i++) begin
      do_reset();
      wr(2'd2, tbl[i].vbase);
      wr(2'd0, tbl[i].imr);
      pulse(tbl[i].irq);
      tick(); tick();
      chk($sformatf("tbl%0d_int", i), 32'(int_out), 32'(tbl[i].exp_int));
      if (tbl[i].exp_int) begin
        do_inta();
        chk($sformatf("tbl%0d_vvalid", i), 32'(vec_valid), 32'h1);
        chk($sformatf("tbl%0d_vec", i), 32'(vec_out), 32'(tbl[i].exp_vec));
        tick();
        ex = 8'h01 << (tbl[i].exp_vec - tbl[i].vbase);
        rd(2'd2, d);
        chk($sformatf("tbl%0d_isr", i), 32'(d), 32'(ex));
      end
    end

    // randomized traffic against the model
    do_reset();
    m_vbase = 8'h30; m_imr = 8'h00; m_irr = '0; m_isr = '0;
    m_rot = 1'b0; m_aeoi = 1'b0; m_int = 1'b0; m_ptr = 7;
    wr(2'd2, m_vbase); wr(2'd0, m_imr);
    for (int it = 0; it < 400; it++) begin
      op = $urandom_range(0, 9);
      case (op)
        0: begin
          m_imr = 8'($urandom) & 8'($urandom) & 8'($urandom);
          wr(2'd0, m_imr);
        end
        1: begin
          m_rot = 1'($urandom); m_aeoi = 1'($urandom);
          wr(2'd1, {5'b0, m_aeoi, m_rot, 1'b0});
        end
        2, 3, 4: begin
          p = 8'($urandom) & 8'($urandom) & 8'($urandom);
          m_irr = m_irr | p;
          pulse(p);
        end
        5, 6: if (m_int) begin
          c = m_cand();
          exp_v = (c >= 0) ? 8'(m_vbase + c) : 8'(m_vbase + 7);
          do_inta();
          chk("rnd_vvalid", 32'(vec_valid), 32'h1);
          chk("rnd_vec", 32'(vec_out), 32'(exp_v));
          if (c >= 0) begin
            m_isr = m_isr | 8'(1 << c);
            m_irr = m_irr & ~8'(1 << c);
            if (m_aeoi) begin
              m_isr = m_isr & ~8'(1 << c);
              if (m_rot) m_ptr = c;
            end
          end
          m_int = 1'b0;
          tick();
          chk("rnd_vvalid_pulse", 32'(vec_valid), 32'h0);
        end
        7: begin
          c = m_best(m_isr);
          wr(2'd3, 8'h00);
          if (c >= 0) begin
            m_isr = m_isr & ~8'(1 << c);
            if (m_rot) m_ptr = c;
          end
        end
        8: begin
          id = $urandom_range(0, 7);
          if (m_isr[id[2:0]]) begin
            wr(2'd3, 8'h80 | 8'(id));
            m_isr = m_isr & ~8'(1 << id);
            if (m_rot) m_ptr = id;
          end
        end
        default: begin
          c = $urandom_range(0, 3);
          rd(2'(c), d);
          case (c)
            0:       ex = m_imr;
            1:       ex = m_irr;
            2:       ex = m_isr;
            default: ex = {5'b0, m_aeoi, m_rot, 1'b0};
          endcase
          chk($sformatf("rnd_rd%0d", c), 32'(d), 32'(ex));
        end
      endcase
      repeat (3) tick();
      if (m_cand() >= 0) m_int = 1'b1;
      chk("rnd_int_out", 32'(int_out), 32'(m_int));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
